serial_add_seq: RTL

//  Multi-cycle add/subtract sequencer that runs one 4-bit carry-lookahead slice over

---
 rtl/serial_add_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq: nibble-serial add/subtract sequencer built around one 4-bit carry-lookahead slice
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand request valid
//   in_ready   high in IDLE, block accepts operands
//   in_a       operand A (W bits)
//   in_b       operand B (W bits)
//   in_sub     1 = A-B, 0 = A+B
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   out_sum    result (W bits), LSB nibble written first
//   out_cout   carry out of the MSB nibble; for subtract, 1 = no borrow
//   out_ovfl   signed two's-complement overflow
//   busy       block is not IDLE
module serial_add_seq #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovfl,
    output logic         busy
);
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_r, b_r;
    logic          carry;
    logic [IW-1:0] idx;
    logic [3:0]    a_n, b_n, p, g, s;
    logic [4:0]    c;
    logic          last;

    // Single 4-bit carry-lookahead slice fed by the current nibble of the latched operands.
    always_comb begin
        a_n  = a_r[4*idx +: 4];
        b_n  = b_r[4*idx +: 4];
        p    = a_n ^ b_n;
        g    = a_n & b_n;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
        last = idx == LAST;
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (in_valid ? RUN : IDLE)
                 : state == RUN  ? (last ? DONE : RUN)
                 : state == DONE ? (out_ready ? IDLE : DONE)
                 : IDLE;
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
    end

    // Subtraction is A + ~B + 1: B is inverted at accept and the +1 enters as the initial carry.
    // The index parks at the last nibble; it restarts from zero on the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovfl <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r     <= in_a;
            b_r     <= in_sub ? ~in_b : in_b;
            carry   <= in_sub;
            idx     <= '0;
            out_sum <= '0;
        end else if (state == RUN) begin
            out_sum[4*idx +: 4] <= s;
            carry               <= c[4];
            if (last) begin
                out_cout <= c[4];
                out_ovfl <= (a_r[W-1] == b_r[W-1]) & (s[3] != a_r[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule
